accum_rmw_ctrl: RTL

Read-modify-write controller that drives the write port and read port of the accumulator's pseudo dual-port RAM as master. It accepts a stream of (address, addend) beats, reads the stored partial sum, adds the addend and writes the result back. Throughput is one beat per cycle, with forwarding that covers the RAM's read-before-write behaviour. A drain sequence streams out every entry and optionally zeroes it. It sits between the PE result path and the accumulator bank RAM.

---
 rtl/accum_rmw_ctrl.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/accum_rmw_ctrl.sv
// accum_rmw_ctrl
//   Read-modify-write controller for the accumulator bank RAM.
//   Every accepted (address, addend) beat runs through three stages:
//     P1  the RAM read is in flight; the beat waits for the old value
//     P2  holds the new sum; the RAM write is issued from here
//     P3  holds the write that was issued last cycle, kept one more cycle
//   One beat can be accepted every cycle. The RAM returns the old value when
//   a read and a write hit the same address on the same edge, so the old value
//   used in P1 is taken from P2 or P3 whenever they hold the same address.
//   A drain streams out every entry in address order and can zero each one.

module accum_rmw_ctrl #(
  parameter int AW             = 6,
  parameter int DW             = 32,
  parameter bit CLEAR_ON_DRAIN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,

  // accumulate beat stream
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          in_clear,

  // drain control and drained-entry stream
  input  logic          drain_start,
  output logic          drain_busy,
  output logic          drain_done,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,

  // RAM write port
  output logic          ram_wr_en,
  output logic          ram_wr_we,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_wdata,

  // RAM read port (data returns one cycle after ram_rd_en)
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_rdata
);

  typedef enum logic [1:0] {
    ACCUM      = 2'd0,
    DRAIN_WAIT = 2'd1,
    DRAIN_RUN  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Pipeline stage registers
  logic          p1_valid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_data;
  logic          p1_clear;

  logic          p2_valid;
  logic [AW-1:0] p2_addr;
  logic [DW-1:0] p2_data;

  logic          p3_valid;
  logic [AW-1:0] p3_addr;
  logic [DW-1:0] p3_data;

  // Drain address counter and its "all addresses issued" flag
  logic [AW-1:0] cnt;
  logic          drain_issued;

  // Registered drained-entry qualifiers (data comes straight from the RAM)
  logic          out_valid_q;
  logic [AW-1:0] out_addr_q;

  // Internal decodes
  logic          accept;
  logic          drain_rd;
  logic          wr_commit;
  logic          last_out;
  logic [DW-1:0] old_value;
  logic [DW-1:0] sum;

  // The RAM-facing outputs are masked by rst so that a reset arriving in the
  // middle of a drain or an accumulate burst never reaches the RAM.
  assign in_ready  = !rst && (state_q == ACCUM) && !drain_start;
  assign accept    = in_valid && in_ready;
  assign drain_rd  = !rst && (state_q == DRAIN_RUN) && !drain_issued;
  assign wr_commit = !rst && p2_valid;
  assign last_out  = out_valid_q && (out_addr_q == {AW{1'b1}});

  assign drain_busy = !rst && (state_q != ACCUM);
  assign drain_done = !rst && last_out;
  assign out_valid  = !rst && out_valid_q;
  assign out_addr   = out_valid ? out_addr_q : '0;
  assign out_data   = out_valid ? ram_rd_rdata : '0;

  // State register
  // NOTE: clocked blocks use non-blocking (<=) so every register samples the
  // pre-edge value of its neighbours; combinational blocks use blocking (=).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: drain waits for in-flight beats to retire, then runs
  // until the last drained entry has been presented.
  // NOTE: every variable written here gets a default first so no path can
  // leave it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: begin
        if (drain_start) begin
          state_d = DRAIN_WAIT;
        end
      end
      DRAIN_WAIT: begin
        if (!p1_valid && !p2_valid) begin
          state_d = DRAIN_RUN;
        end
      end
      DRAIN_RUN: begin
        if (last_out) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // Old value for the beat in P1: the two most recent writes are newer than
  // what the RAM returned, and P2 is the newer of the two.
  always_comb begin
    old_value = ram_rd_rdata;
    if (p2_valid && (p2_addr == p1_addr)) begin
      old_value = p2_data;
    end else if (p3_valid && (p3_addr == p1_addr)) begin
      old_value = p3_data;
    end
    sum = p1_clear ? p1_data : (old_value + p1_data);
  end

  // Pipeline valid bits: cleared by reset so no stale beat is ever written.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p2_valid <= 1'b0;
      p3_valid <= 1'b0;
    end else begin
      p1_valid <= accept;
      p2_valid <= p1_valid;
      p3_valid <= p2_valid;
    end
  end

  // Pipeline payload: advances only behind its valid bit.
  // NOTE: payload registers carry no reset; they are only ever consumed
  // behind a valid bit that is reset, which keeps the reset tree small.
  always_ff @(posedge clk) begin
    if (accept) begin
      p1_addr  <= in_addr;
      p1_data  <= in_data;
      p1_clear <= in_clear;
    end
    if (p1_valid) begin
      p2_addr <= p1_addr;
      p2_data <= sum;
    end
    if (p2_valid) begin
      p3_addr <= p2_addr;
      p3_data <= p2_data;
    end
  end

  // Drain counter: walks every address once per drain, then parks until the
  // FSM returns to ACCUM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      drain_issued <= 1'b0;
    end else if (state_q != DRAIN_RUN) begin
      cnt          <= '0;
      drain_issued <= 1'b0;
    end else if (!drain_issued) begin
      if (cnt == {AW{1'b1}}) begin
        drain_issued <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Drained-entry qualifiers line up with the RAM read data one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      out_valid_q <= drain_rd;
      out_addr_q  <= cnt;
    end
  end

  // RAM port steering. Drain reads and accumulate reads never overlap, and a
  // drain only starts once P2 is empty, so the write sources never collide.
  always_comb begin
    ram_rd_en    = 1'b0;
    ram_rd_addr  = '0;
    ram_wr_en    = 1'b0;
    ram_wr_we    = 1'b0;
    ram_wr_addr  = '0;
    ram_wr_wdata = '0;

    if (drain_rd) begin
      ram_rd_en   = 1'b1;
      ram_rd_addr = cnt;
      if (CLEAR_ON_DRAIN) begin
        ram_wr_en    = 1'b1;
        ram_wr_we    = 1'b1;
        ram_wr_addr  = cnt;
        ram_wr_wdata = '0;
      end
    end else if (accept) begin
      ram_rd_en   = 1'b1;
      ram_rd_addr = in_addr;
    end

    if (wr_commit) begin
      ram_wr_en    = 1'b1;
      ram_wr_we    = 1'b1;
      ram_wr_addr  = p2_addr;
      ram_wr_wdata = p2_data;
    end
  end

endmodule
